skew_align_rx: RTL and testbench
================================

# skew_align_rx

Receive-side lane aligner for the pipelined, per-gate-clocked netlists our flow produces. Compensates at the consumer instead of padding inside the netlist: each output lane i of an unbalanced netlist emerges d_i clock stages after its input vector is launched. The block delays every lane by (D_max − d_i) so all bits of one launch leave together. It also regenerates a single valid strobe per launch. It sits between the netlist outputs and the capture/compare logic.

## Interface
- N_OUT, default 2: number of netlist output lanes.
- MAX_DEPTH, default 8: largest supported lane depth in stages.
- DEPTH_W, default 4: width of depth fields; must satisfy 2^DEPTH_W > MAX_DEPTH.
- clk  in  1  single clock for all state.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  write cfg_depth into the depth register of lane cfg_idx.
- cfg_idx  in  clog2(N_OUT)  lane being configured.
- cfg_depth  in  DEPTH_W  stage depth d_i of that lane.
- cfg_commit  in  1  start arming with the current depths.
- cfg_clear  in  1  return to IDLE and flush.
- in_valid  in  1  marks the launch cycle of an input vector.
- in_data  in  N_OUT  raw lane bits from the netlist, sampled every cycle.
- out_valid  out  1  aligned vector present.
- out_data  out  N_OUT  aligned lane bits.
- ready  out  1  high in RUN.
- cfg_err  out  1  sticky configuration error.
- drop  out  1  sticky: an in_valid occurred outside RUN.
- out_count  out  16  emitted-vector count (only with SKEW_ALIGN_CNT_EN).

## Operation
- FSM states: IDLE, ARM, RUN. Reset enters IDLE.
- IDLE:
  - cfg_we writes depth[cfg_idx].
  - If cfg_depth > MAX_DEPTH, the stored depth clamps to MAX_DEPTH and cfg_err is set.
  - An out-of-range cfg_idx leaves all depths unchanged and sets cfg_err.
- cfg_commit in IDLE → ARM.
  - ARM scans one lane per cycle, N_OUT cycles total, and computes D_max = max(depth[i]).
  - On the last scan cycle: the lane delays L_i = D_max − depth[i] are latched, the valid pipeline is cleared, and the FSM goes to RUN.
- RUN:
  - ready=1.
  - A valid shift register of length MAX_DEPTH+1 tracks launches.
  - Each lane has a shift register of length MAX_DEPTH+1; lane i output taps position L_i.
- cfg_we or cfg_commit outside IDLE is ignored and sets cfg_err.
- cfg_clear in any state → IDLE, clears the valid pipeline and out_valid. Depths, cfg_err and drop are kept.
- cfg_clear together with cfg_commit: cfg_clear wins.
- in_valid in IDLE or ARM is discarded and sets drop.
- cfg_err and drop clear only on rst.
- Lane data shift registers shift every cycle in all states; only the valid path is gated.
- All depths 0: D_max=0, every L_i=0, and the block becomes a one-register pipeline.

## Timing
- Reset values: out_valid=0, out_data=0, ready=0, cfg_err=0, drop=0, out_count=0, all depths=0, all lane and valid shift registers=0.
- Launch latency: in_valid at cycle t in RUN → out_valid at t+D_max+1. out_data at that cycle equals in_data[i] sampled at cycle t+depth[i].
- Back-to-back in_valid gives back-to-back out_valid. Throughput is one vector per cycle, with no stall or backpressure.
- The ARM → RUN transition takes exactly N_OUT cycles after the cycle in which cfg_commit is sampled.
- Launches issued in the last D_max cycles before cfg_clear are lost; no partial vector is emitted.
- Asynchronous rst mid-RUN forces all outputs to their reset values immediately.

## Configuration
- SKEW_ALIGN_CNT_EN:
  - Defined: out_count increments on each out_valid, saturates at 16'hFFFF, and is cleared only by rst.
  - Undefined: the counter logic is absent and out_count is tied to 0.

## Test plan
Common setup: N_OUT=2, MAX_DEPTH=8.
- Basic alignment:
  - Stimulus: depths {3,5}, commit; in_valid at cycle 10; drive in_data[0]=1 at cycle 13 and in_data[1]=1 at cycle 15, all other lane bits 0.
  - Response: ARM lasts 2 cycles; single out_valid at cycle 16 with out_data=2'b11.
- Streaming:
  - Stimulus: same depths; 4 consecutive in_valid launches with alternating lane patterns.
  - Response: 4 consecutive out_valid cycles in launch order; out_count=4 when SKEW_ALIGN_CNT_EN is defined.
- Clamp:
  - Stimulus: write depth 12 to lane 1.
  - Response: cfg_err=1; D_max=8; lane 0 at depth 0 is delayed 8 stages.
- Misuse:
  - Stimulus: in_valid in IDLE, then cfg_we in RUN.
  - Response: drop=1, cfg_err=1, depths unchanged, no out_valid.
- Flush:
  - Stimulus: cfg_clear issued 2 cycles after a launch, with D_max=5.
  - Response: no out_valid for that launch; ready=0 the next cycle.
- Reset:
  - Stimulus: rst asserted while vectors are in flight.
  - Response: all outputs 0 without waiting for a clock edge; state is IDLE after release.

Source files
------------

// File: rtl/skew_align_rx.sv
// Receive-side lane aligner: delays lane i by (D_max - depth[i]) so all bits of one launch leave together.
// Optional feature macro SKEW_ALIGN_CNT_EN adds a saturating 16-bit emitted-vector counter on out_count.
module skew_align_rx #(
    parameter int N_OUT       = 2,
    parameter int MAX_DEPTH   = 8,
    parameter int DEPTH_W     = 4,
    localparam int IDX_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [DEPTH_W-1:0] cfg_depth,
    input  logic               cfg_commit,
    input  logic               cfg_clear,
    input  logic               in_valid,
    input  logic [N_OUT-1:0]   in_data,
    output logic               out_valid,
    output logic [N_OUT-1:0]   out_data,
    output logic               ready,
    output logic               cfg_err,
    output logic               drop,
    output logic [15:0]        out_count
);

    localparam logic [DEPTH_W-1:0] MAX_D    = DEPTH_W'(MAX_DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q [N_OUT];
    logic [DEPTH_W-1:0]   depth_d [N_OUT];
    logic [DEPTH_W-1:0]   lat_q   [N_OUT];
    logic [DEPTH_W-1:0]   lat_d   [N_OUT];
    logic [DEPTH_W-1:0]   dmax_q, dmax_d;
    logic [DEPTH_W-1:0]   maxacc_q, maxacc_d;
    logic [DEPTH_W-1:0]   cand_s;
    logic [IDX_W-1:0]     scan_q, scan_d;
    logic [MAX_DEPTH-1:0] vld_sr_q, vld_sr_d;
    logic [MAX_DEPTH:0]   vld_pos_s;
    logic [MAX_DEPTH-1:0] lane_sr_q  [N_OUT];
    logic [MAX_DEPTH-1:0] lane_sr_d  [N_OUT];
    logic [MAX_DEPTH:0]   lane_pos_s [N_OUT];
    logic                 out_valid_q, out_valid_d;
    logic [N_OUT-1:0]     out_data_q, out_data_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 drop_q, drop_d;
    logic                 launch_s, flush_s, idx_ok_s;

    // Control FSM: depth writes, ARM max-scan, RUN gating, sticky error/drop flags
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        lat_d     = lat_q;
        dmax_d    = dmax_q;
        maxacc_d  = maxacc_q;
        scan_d    = scan_q;
        cfg_err_d = cfg_err_q;
        drop_d    = drop_q;
        cand_s    = maxacc_q;
        launch_s  = 1'b0;
        flush_s   = 1'b0;
        idx_ok_s  = (int'(cfg_idx) < N_OUT);
        case (state_q)
            ST_IDLE: begin
                if (cfg_we && idx_ok_s) begin
                    depth_d[cfg_idx] = (cfg_depth > MAX_D) ? MAX_D : cfg_depth;
                end else begin
                    depth_d = depth_q;
                end
                cfg_err_d = cfg_err_q | (cfg_we & (~idx_ok_s | (cfg_depth > MAX_D)));
                drop_d    = drop_q | in_valid;
                if (cfg_commit) begin
                    state_d  = ST_ARM;
                    scan_d   = '0;
                    maxacc_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                cand_s    = (depth_q[scan_q] > maxacc_q) ? depth_q[scan_q] : maxacc_q;
                maxacc_d  = cand_s;
                cfg_err_d = cfg_err_q | cfg_we | cfg_commit;
                drop_d    = drop_q | in_valid;
                // Last scan cycle: cand_s is the final D_max, so latch lane delays now
                if (scan_q == LAST_IDX) begin
                    dmax_d = cand_s;
                    for (int i = 0; i < N_OUT; i++) begin
                        lat_d[i] = cand_s - depth_q[i];
                    end
                    flush_s = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    scan_d = scan_q + IDX_W'(1);
                end
            end
            ST_RUN: begin
                launch_s  = in_valid;
                cfg_err_d = cfg_err_q | cfg_we | cfg_commit;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        flush_s = flush_s | cfg_clear;
        state_d = cfg_clear ? ST_IDLE : state_d;
    end

    // Valid and lane shift registers; position 0 is the live input so depth 0 is one register
    always_comb begin
        out_data_d  = '0;
        vld_pos_s   = {vld_sr_q, launch_s};
        vld_sr_d    = flush_s ? '0 : vld_pos_s[MAX_DEPTH-1:0];
        out_valid_d = (state_q == ST_RUN) && !cfg_clear && vld_pos_s[dmax_q];
        for (int i = 0; i < N_OUT; i++) begin
            lane_pos_s[i] = {lane_sr_q[i], in_data[i]};
            lane_sr_d[i]  = lane_pos_s[i][MAX_DEPTH-1:0];
            out_data_d[i] = lane_pos_s[i][lat_q[i]];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dmax_q      <= '0;
            maxacc_q    <= '0;
            scan_q      <= '0;
            vld_sr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            drop_q      <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                depth_q[i]   <= '0;
                lat_q[i]     <= '0;
                lane_sr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            lat_q       <= lat_d;
            dmax_q      <= dmax_d;
            maxacc_q    <= maxacc_d;
            scan_q      <= scan_d;
            vld_sr_q    <= vld_sr_d;
            lane_sr_q   <= lane_sr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
            drop_q      <= drop_d;
        end
    end

`ifdef SKEW_ALIGN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of emitted vectors, cleared only by rst
    always_comb begin
        cnt_d = (out_valid_q && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`else
    assign out_count = 16'h0000;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ready     = (state_q == ST_RUN);
    assign cfg_err   = cfg_err_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_skew_align_rx.sv
// Directed bench for skew_align_rx: a vector table for alignment/streaming plus hand sequences
// for clamp, misuse, flush and asynchronous reset.
module tb_skew_align_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [0:0]  cfg_idx = 1'b0;
    logic [3:0]  cfg_depth = 4'd0;
    logic        cfg_commit = 1'b0;
    logic        cfg_clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_data = 2'b00;
    logic        out_valid;
    logic [1:0]  out_data;
    logic        ready;
    logic        cfg_err;
    logic        drop;
    logic [15:0] out_count;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       we;
        logic       idx;
        logic [3:0] dep;
        logic       com;
        logic       v;
        logic [1:0] din;
        logic       ev;
        logic [1:0] ed;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    skew_align_rx #(.N_OUT(2), .MAX_DEPTH(8), .DEPTH_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_depth  (cfg_depth),
        .cfg_commit (cfg_commit),
        .cfg_clear  (cfg_clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .ready      (ready),
        .cfg_err    (cfg_err),
        .drop       (drop),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic idx, input logic [3:0] dep,
                         input logic com, input logic clr, input logic v, input logic [1:0] din);
        cfg_we     = we;
        cfg_idx    = idx;
        cfg_depth  = dep;
        cfg_commit = com;
        cfg_clear  = clr;
        in_valid   = v;
        in_data    = din;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic do_reset(input string tag);
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check({tag, "_rst_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_rst_ready"}, 16'(ready), 16'd0);
        check({tag, "_rst_err"}, 16'(cfg_err), 16'd0);
        check({tag, "_rst_drop"}, 16'(drop), 16'd0);
    endtask

    // Write both depths and commit; ARM must last exactly two cycles
    task automatic arm(input string tag, input logic [3:0] d0, input logic [3:0] d1);
        drive(1'b1, 1'b0, d0, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        drive(1'b1, 1'b1, d1, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00);
        step();
        check({tag, "_arm1_ready"}, 16'(ready), 16'd0);
        idle();
        step();
        check({tag, "_arm2_ready"}, 16'(ready), 16'd0);
        step();
        check({tag, "_run_ready"}, 16'(ready), 16'd1);
    endtask

    function automatic void add(input logic we, input logic idx, input logic [3:0] dep,
                                input logic com, input logic v, input logic [1:0] din,
                                input logic ev, input logic [1:0] ed, input logic rdy);
        vec_t r;
        r.we = we; r.idx = idx; r.dep = dep; r.com = com; r.v = v; r.din = din;
        r.ev = ev; r.ed = ed; r.rdy = rdy;
        tbl.push_back(r);
    endfunction

    initial begin
        logic seen_v;

        // Basic alignment: depths {3,5}, D_max=5, launch at r5, output after r10
        add(1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0); // r0
        add(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0); // r1
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0); // r2 commit
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0); // r3 ARM
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1); // r4 -> RUN
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1); // r5 launch
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1); // r8 lane0
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b11, 1'b1); // r10 lane1, out
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        // Streaming: launches r12..r15 with patterns 01,10,01,10
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1); // r12
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1); // r15
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b1); // r17
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b1); // r20
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1);

        #2;
        check("por_valid", 16'(out_valid), 16'd0);
        check("por_data", 16'(out_data), 16'd0);
        check("por_count", out_count, 16'd0);
        do_reset("init");

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].we, tbl[k].idx, tbl[k].dep, tbl[k].com, 1'b0, tbl[k].v, tbl[k].din);
            step();
            check($sformatf("row%0d_valid", k), 16'(out_valid), 16'(tbl[k].ev));
            check($sformatf("row%0d_ready", k), 16'(ready), 16'(tbl[k].rdy));
            check($sformatf("row%0d_err", k), 16'(cfg_err), 16'd0);
            check($sformatf("row%0d_drop", k), 16'(drop), 16'd0);
            if (tbl[k].ev) begin
                check($sformatf("row%0d_data", k), 16'(out_data), 16'(tbl[k].ed));
            end
        end
        idle();
        step();
`ifdef SKEW_ALIGN_CNT_EN
        // One basic vector plus four streamed vectors since reset
        check("stream_count", out_count, 16'd5);
`else
        check("stream_count", out_count, 16'd0);
`endif

        // Clamp: lane1 depth 12 -> 8, lane0 depth 0 delayed 8 stages
        do_reset("clamp");
        arm("clamp", 4'd0, 4'd12);
        check("clamp_err", 16'(cfg_err), 16'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
        step();
        check("clamp_v0", 16'(out_valid), 16'd0);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, (k == 8) ? 2'b10 : 2'b00);
            step();
            if (k < 8) begin
                check($sformatf("clamp_v%0d", k), 16'(out_valid), 16'd0);
            end else begin
                check("clamp_out_valid", 16'(out_valid), 16'd1);
                check("clamp_out_data", 16'(out_data), 16'd3);
            end
        end
        idle();

        // Misuse: in_valid in IDLE, cfg_we in RUN
        do_reset("misuse");
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b11);
        step();
        check("misuse_drop", 16'(drop), 16'd1);
        check("misuse_err0", 16'(cfg_err), 16'd0);
        arm("misuse", 4'd2, 4'd2);
        check("misuse_novalid", 16'(out_valid), 16'd0);
        drive(1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        check("misuse_err", 16'(cfg_err), 16'd1);
        check("misuse_ready", 16'(ready), 16'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00);
        step();
        check("misuse_v0", 16'(out_valid), 16'd0);
        idle();
        step();
        check("misuse_v1", 16'(out_valid), 16'd0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11);
        step();
        check("misuse_out_valid", 16'(out_valid), 16'd1);
        check("misuse_out_data", 16'(out_data), 16'd3);
        check("misuse_drop_kept", 16'(drop), 16'd1);
        idle();

        // Flush: launch, clear two cycles later with D_max=5
        do_reset("flush");
        arm("flush", 4'd3, 4'd5);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b11);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11);
        step();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'b11);
        step();
        check("flush_ready", 16'(ready), 16'd0);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11);
        seen_v = out_valid;
        for (int k = 0; k < 6; k++) begin
            step();
            seen_v = seen_v | out_valid;
        end
        check("flush_no_valid", 16'(seen_v), 16'd0);
        check("flush_drop", 16'(drop), 16'd0);
        idle();

        // Asynchronous reset with vectors in flight
        do_reset("areset");
        arm("areset", 4'd1, 4'd2);
        drive(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 2'b11);
        step();
        check("areset_err", 16'(cfg_err), 16'd1);
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b11);
        step();
        step();
        step();
        check("areset_pre_valid", 16'(out_valid), 16'd1);
        check("areset_pre_data", 16'(out_data), 16'd3);
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", 16'(out_valid), 16'd0);
        check("areset_data", 16'(out_data), 16'd0);
        check("areset_ready", 16'(ready), 16'd0);
        check("areset_err0", 16'(cfg_err), 16'd0);
        check("areset_drop", 16'(drop), 16'd0);
        check("areset_count", out_count, 16'd0);
        idle();
        step();
        rst = 1'b0;
        step();
        check("areset_idle_ready", 16'(ready), 16'd0);
        seen_v = out_valid;
        for (int k = 0; k < 4; k++) begin
            step();
            seen_v = seen_v | out_valid | ready;
        end
        check("areset_idle_quiet", 16'(seen_v), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
